// File: rtl/nlp_predictor.sv
// -----------------------------------------------------------------------------
// nlp_predictor
//
// Next-line predictor for the dual-issue fetch unit. The IF1 fetch PC is looked
// up in a two-bank, direct-mapped, tagged BTB with a 2-bit bimodal counter per
// entry. The per-slot prediction is registered and presented to IF2 one cycle
// later. IF3 trains entries through two update ports.
//
// The bank is selected by pc[2], so the two slots of a fetch pair
// (lookupPC, lookupPC+4) always fall into different banks.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   stall                   holds the prediction registers, ignores lookupPC
//   lookupPC                IF1 fetch PC (slot0 = lookupPC, slot1 = lookupPC+4)
//   nlpN_valid              tag hit for slot N
//   nlpN_taken              bimState[1] on a hit, else 0
//   nlpN_target             predicted target (0 on a miss)
//   nlpN_bimState           current counter (0 on a miss)
//   updateN_valid           IF3 training request for port N
//   updateN_pc              PC of the instruction being trained
//   updateN_target          target to store
//   updateN_bimState        counter value IF3 saw (2'b01 on an NLP miss)
//   updateN_shouldTake      training direction
// -----------------------------------------------------------------------------
module nlp_predictor #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic [31:0] lookupPC,

    output logic        nlp0_valid,
    output logic        nlp0_taken,
    output logic [31:0] nlp0_target,
    output logic [1:0]  nlp0_bimState,
    output logic        nlp1_valid,
    output logic        nlp1_taken,
    output logic [31:0] nlp1_target,
    output logic [1:0]  nlp1_bimState,

    input  logic        update0_valid,
    input  logic [31:0] update0_pc,
    input  logic [31:0] update0_target,
    input  logic [1:0]  update0_bimState,
    input  logic        update0_shouldTake,
    input  logic        update1_valid,
    input  logic [31:0] update1_pc,
    input  logic [31:0] update1_target,
    input  logic [1:0]  update1_bimState,
    input  logic        update1_shouldTake
);

    localparam int NE    = 1 << IDX_W;
    localparam int IDX_L = 3;
    localparam int TAG_L = IDX_W + 3;

    // Saturating 2-bit bimodal counter step.
    function automatic logic [1:0] bim_next(input logic [1:0] old, input logic take);
        if (take)
            return (old == 2'b11) ? 2'b11 : old + 2'b01;
        else
            return (old == 2'b00) ? 2'b00 : old - 2'b01;
    endfunction

    // Entry storage. Only the valid bits are reset; the rest is don't-care
    // until an update allocates the entry.
    logic             ent_valid  [0:1][0:NE-1];
    logic [TAG_W-1:0] ent_tag    [0:1][0:NE-1];
    logic [31:0]      ent_target [0:1][0:NE-1];
    logic [1:0]       ent_bim    [0:1][0:NE-1];

    // Update address fields
    logic             u0_bank, u1_bank;
    logic [IDX_W-1:0] u0_idx,  u1_idx;
    logic [TAG_W-1:0] u0_tag,  u1_tag;

    assign u0_bank = update0_pc[2];
    assign u0_idx  = update0_pc[IDX_W+IDX_L-1:IDX_L];
    assign u0_tag  = update0_pc[TAG_W+TAG_L-1:TAG_L];
    assign u1_bank = update1_pc[2];
    assign u1_idx  = update1_pc[IDX_W+IDX_L-1:IDX_L];
    assign u1_tag  = update1_pc[TAG_W+TAG_L-1:TAG_L];

    // Valid bits: port1 is written last so it wins a same-entry conflict
    // (both write 1 here, but the ordering mirrors the data array).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < NE; i++)
                    ent_valid[b][i] <= 1'b0;
        end else begin
            if (update0_valid) ent_valid[u0_bank][u0_idx] <= 1'b1;
            if (update1_valid) ent_valid[u1_bank][u1_idx] <= 1'b1;
        end
    end

    // Entry payload: allocate-on-update, port1 overrides port0 on the same entry.
    always_ff @(posedge clk) begin
        if (update0_valid) begin
            ent_tag[u0_bank][u0_idx]    <= u0_tag;
            ent_target[u0_bank][u0_idx] <= update0_target;
            ent_bim[u0_bank][u0_idx]    <= bim_next(update0_bimState, update0_shouldTake);
        end
        if (update1_valid) begin
            ent_tag[u1_bank][u1_idx]    <= u1_tag;
            ent_target[u1_bank][u1_idx] <= update1_target;
            ent_bim[u1_bank][u1_idx]    <= bim_next(update1_bimState, update1_shouldTake);
        end
    end

    // ---- stage p0: IF1 lookup (combinational read of the current contents) ----
    logic [31:0]      pc1_p0;
    logic             bank0_p0, bank1_p0;
    logic [IDX_W-1:0] idx0_p0,  idx1_p0;
    logic [TAG_W-1:0] tag0_p0,  tag1_p0;
    logic             hit0_p0,  hit1_p0;

    // Slot1 address is recomputed from PC+4 so index/tag carries are exact.
    assign pc1_p0   = lookupPC + 32'd4;
    assign bank0_p0 = lookupPC[2];
    assign idx0_p0  = lookupPC[IDX_W+IDX_L-1:IDX_L];
    assign tag0_p0  = lookupPC[TAG_W+TAG_L-1:TAG_L];
    assign bank1_p0 = pc1_p0[2];
    assign idx1_p0  = pc1_p0[IDX_W+IDX_L-1:IDX_L];
    assign tag1_p0  = pc1_p0[TAG_W+TAG_L-1:TAG_L];

    assign hit0_p0 = ent_valid[bank0_p0][idx0_p0] && (ent_tag[bank0_p0][idx0_p0] == tag0_p0);
    assign hit1_p0 = ent_valid[bank1_p0][idx1_p0] && (ent_tag[bank1_p0][idx1_p0] == tag1_p0);

    // ---- stage p1: registered prediction to IF2 (all-zero on a miss) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nlp0_valid    <= 1'b0;
            nlp0_taken    <= 1'b0;
            nlp0_target   <= '0;
            nlp0_bimState <= '0;
            nlp1_valid    <= 1'b0;
            nlp1_taken    <= 1'b0;
            nlp1_target   <= '0;
            nlp1_bimState <= '0;
        end else if (!stall) begin
            nlp0_valid    <= hit0_p0;
            nlp0_taken    <= hit0_p0 & ent_bim[bank0_p0][idx0_p0][1];
            nlp0_target   <= hit0_p0 ? ent_target[bank0_p0][idx0_p0] : 32'd0;
            nlp0_bimState <= hit0_p0 ? ent_bim[bank0_p0][idx0_p0] : 2'b00;
            nlp1_valid    <= hit1_p0;
            nlp1_taken    <= hit1_p0 & ent_bim[bank1_p0][idx1_p0][1];
            nlp1_target   <= hit1_p0 ? ent_target[bank1_p0][idx1_p0] : 32'd0;
            nlp1_bimState <= hit1_p0 ? ent_bim[bank1_p0][idx1_p0] : 2'b00;
        end
    end

    // PC bits outside the index/tag/bank fields do not participate.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookupPC, pc1_p0, update0_pc, update1_pc};

endmodule

// File: doc/nlp_predictor.md
# nlp_predictor

- Next-line predictor (NLP) for the dual-issue fetch unit.
- Looks up the fetch PC at IF1 and returns per-slot `nlpInfo` (valid, taken, target, bimState) to IF2 one cycle later.
- Is the consumer of the `NLPUpdate` traffic from IF3: each IF3 update trains a direct-mapped, tagged BTB entry and its 2-bit bimodal counter.
- Two banks, selected by PC[2], so the inst0/inst1 slots of a fetch pair always hit different banks.

## Interface

**Parameters**
- `IDX_W`, default 4: index bits per bank (2^IDX_W entries per bank).
- `TAG_W`, default 8: stored tag bits.

**Ports** (name, direction, width, meaning)
- `clk` in 1: clock.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `stall` in 1: fetch stall; holds the lookup output registers.
- `lookupPC` in 32: IF1 fetch PC. Slot0 = `lookupPC`, slot1 = `lookupPC+4`.
- `nlp0_valid` / `nlp1_valid` out 1: tag hit for slot0 / slot1.
- `nlp0_taken` / `nlp1_taken` out 1: predicted taken, equal to `bimState[1]` on a hit, else 0.
- `nlp0_target` / `nlp1_target` out 32: predicted target.
- `nlp0_bimState` / `nlp1_bimState` out 2: current counter, returned to IF3 with the instruction.
- `update0_valid` / `update1_valid` in 1: IF3 update request for slot0 / slot1.
- `update0_pc` / `update1_pc` in 32: PC of the instruction being trained.
- `update0_target` / `update1_target` in 32: target to store.
- `update0_bimState` / `update1_bimState` in 2: old counter (IF3 supplies 2'b01 on an NLP miss).
- `update0_shouldTake` / `update1_shouldTake` in 1: training direction.

## Operation

**Address fields**
- bank = pc[2]
- index = pc[IDX_W+2:3]
- tag = pc[TAG_W+IDX_W+2:IDX_W+3]

**Entry contents:** valid, tag, target[31:0], bim[1:0].

**Lookup**
- Compute bank, index and tag independently for `lookupPC` and `lookupPC+4`, including carry across an index boundary.
- Hit = entry.valid && entry.tag == pc tag.
- Route each slot's result from whichever bank its PC maps to; slot numbering follows PC order, not bank number.

**Update (per port)**
- Write to the bank and index derived from `updateN_pc`: valid=1, tag, target, and bim = sat(old ± 1).
- Counter rule: `shouldTake`=1 → min(old+1, 3); `shouldTake`=0 → max(old−1, 0).
- An update always overwrites the entry (allocate-on-update); it is never conditional on a hit.

**Write conflict:** if both ports address the same bank and index in one cycle, update1 wins.

**Miss outputs:** on a miss, `valid`, `taken`, `bimState` and `target` are all 0. This gives IF3 X-free compares.

**Reset:** all entry valid bits and all output registers are cleared. Tags, targets and bim are don't-care. A reset asserted mid-operation clears everything immediately; any update in flight is lost.

## Timing

- Lookup latency is 1 cycle. `lookupPC` sampled at edge N drives `nlp*` from after edge N until edge N+1.
- Outputs are registered. `stall`=1 holds all `nlp*` outputs and ignores `lookupPC`.
- Updates commit at the clock edge, independent of `stall`.
- There is no read-after-write bypass. A lookup in the same cycle as an update to the same entry returns the old contents; the new contents are visible to lookups sampled at the next edge.
- Both update ports may commit in the same cycle.

## Test plan

- **Reset:** assert `rst_n`=0 mid-run with entries valid; deassert; look up 0x80001000 → `nlp0_valid`=0, `nlp0_taken`=0, `nlp0_target`=0.
- **Allocate + hit:**
  - Stimulus: update0 with pc=0x80001000, target=0x80002000, bimState=01, shouldTake=1; next cycle look up 0x80001000.
  - Required: `nlp0_valid`=1, `nlp0_bimState`=10, `nlp0_taken`=1, `nlp0_target`=0x80002000; slot1 (0x80001004, bank1) misses.
- **Slot1 / bank1 and pair crossing:** train pc=0x8000107C; look up 0x80001078 → `nlp1_valid`=1 and `nlp0_valid`=0. Look up 0x8000107C → hit appears on slot0.
- **Saturation:**
  - Repeated shouldTake=1 from 11 stays 11.
  - shouldTake=0 from 00 stays 00, with `nlp_taken`=0.
  - 10 + not-take → 01, with taken=0.
- **Tag alias:** entry trained at 0x80001000 (tag 0x20); look up 0x80001800 (same index, tag 0x30) → miss. Train 0x80001800 → 0x80001000 now misses.
- **Simultaneous events:**
  - Update and lookup of the same entry in one cycle → old data returned; new data on the next lookup.
  - Two updates to the same bank and index → update1's target is stored.
  - `stall`=1 with a changing `lookupPC` → outputs unchanged while the update still commits.
